input_conditioner: RTL and testbench
====================================

Name: input_conditioner

Overview:
- Front-end stage feeding the bus-demo top level.
- Takes raw board pushbuttons (KEY, active-low) and slide switches (SW) and synchronises and debounces each bit independently.
- Produces clean levels for reset/ena/state_in selection and a single-cycle press pulse per key, used for start/step.
- Runs on the board clock, upstream of the clock divider and top_level.

Parameters:
N_KEY, 4, number of pushbutton inputs
N_SW, 18, number of slide-switch inputs
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a change (10 ms at 50 MHz); legal range >= 1
CW, $clog2(DEBOUNCE_CYCLES+1), counter width (derived, not overridden)

Ports:
clk  input  1  board clock (CLOCK_50)
reset  input  1  synchronous, active-low reset (reset==0 resets on the rising clk edge)
key_raw  input  N_KEY  raw pushbuttons, 0 = pressed, asynchronous to clk
sw_raw  input  N_SW  raw slide switches, 1 = up, asynchronous to clk
key_level  output  N_KEY  debounced key state, 1 = pressed (inverted from raw)
key_press  output  N_KEY  one-cycle pulse on debounced press (0->1 of key_level)
key_release  output  N_KEY  one-cycle pulse on debounced release (1->0 of key_level)
sw_level  output  N_SW  debounced switch state
sw_change  output  N_SW  one-cycle pulse on any debounced switch transition

Behaviour:
- Channels: N_KEY+N_SW identical independent bit channels. Key channels invert the raw input before the synchroniser; switch channels do not.
- Synchroniser: two flops per channel (s1 <= in, s2 <= s1). Reset value is 0 after inversion, i.e. key idle/not pressed, switch down.
- Per-channel state: debounced level d, counter cnt[CW-1:0]. Every edge, when not in reset:
  - s2 == d: cnt <= 0.
  - s2 != d and cnt == DEBOUNCE_CYCLES-1: d <= s2, cnt <= 0, fire the edge pulse.
  - s2 != d otherwise: cnt <= cnt+1.
- Latency: a raw change set up before edge k, held stable, updates d at edge k+DEBOUNCE_CYCLES+1. The pulse is high for exactly the cycle following that edge.
- Pulses are registered. They assert in the same edge d updates and clear on the next edge. key_press=1 when d goes 0->1, key_release=1 when 1->0, sw_change=1 on either direction.
- Glitch rejection: if s2 returns to d before cnt reaches DEBOUNCE_CYCLES-1, cnt clears and no output changes. A glitch of fewer than DEBOUNCE_CYCLES cycles is always rejected.
- Sustained bouncing: the counter restarts on every bounce. The accepted change happens DEBOUNCE_CYCLES cycles after the last bounce.
- DEBOUNCE_CYCLES==1: d follows s2 one cycle late; the pulse still fires once per transition.
- Reset: all s1, s2, d, cnt and pulse registers clear to 0 (keys not pressed, switches down, no pulses).
  - Reset takes priority over every other action.
  - Reset mid-count discards the pending change.
  - A key held or switch up through reset release is re-accepted normally and produces its press/change pulse DEBOUNCE_CYCLES+1 edges later.
- Counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap.
- Simultaneous changes on different channels are fully independent; pulses may coincide.
- No combinational path from any input to any output.

Test Plan:
All with DEBOUNCE_CYCLES=4, N_KEY=4, N_SW=18.
1. Reset: hold reset=0 for 3 cycles with key_raw=4'b0000 and sw_raw=18'h3FFFF -> all outputs 0 during reset. Release -> key_level=4'hF and sw_level=18'h3FFFF 5 edges later; key_press=4'hF and sw_change=18'h3FFFF for exactly one cycle.
2. Clean press: key_raw[0] 1->0 before edge k, held -> key_level[0] rises after edge k+5; key_press[0]=1 only in the cycle after k+5. Release the key -> key_release[0] pulse 5 edges after the release.
3. Glitch: key_raw[1] low for 3 cycles then high -> key_level[1] stays 0; key_press stays 4'h0 throughout.
4. Bounce: sw_raw[15] toggles 0,1,0,1 on successive cycles, then stays 1 -> exactly one sw_change[15] pulse, 5 edges after the final 0->1. sw_level[15]=1.
5. Reset mid-operation: key_raw[2] held low, reset=0 asserted at cnt==2 -> no pulse, key_level[2]=0. After release, key_press[2] fires 5 edges later.
6. Simultaneous events: key_raw[3] pressed and sw_raw[4:0] changed 5'b00000->5'b10101 on the same edge -> key_press[3] and sw_change[4:0]=5'b10101 pulse in the same cycle; sw_level[4:0]=5'b10101.

Source files
------------

// File: rtl/input_conditioner_if.sv
// input_conditioner_if: raw board inputs in, debounced levels and edge pulses out.
interface input_conditioner_if #(
    parameter int N_KEY = 4,
    parameter int N_SW  = 18
);
    logic [N_KEY-1:0] key_raw;
    logic [N_KEY-1:0] key_level;
    logic [N_KEY-1:0] key_press;
    logic [N_KEY-1:0] key_release;
    logic [N_SW-1:0]  sw_raw;
    logic [N_SW-1:0]  sw_level;
    logic [N_SW-1:0]  sw_change;

    modport master (
        output key_raw, sw_raw,
        input  key_level, key_press, key_release, sw_level, sw_change
    );

    modport slave (
        input  key_raw, sw_raw,
        output key_level, key_press, key_release, sw_level, sw_change
    );
endinterface

// File: rtl/input_conditioner.sv
// input_conditioner: synchronises and debounces each key/switch bit, emitting clean levels and edge pulses.
module input_conditioner #(
    parameter int N_KEY           = 4,
    parameter int N_SW            = 18,
    parameter int DEBOUNCE_CYCLES = 500000,
    localparam int CW             = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input logic                clk,
    input logic                reset,
    input_conditioner_if.slave io
);
    localparam int N = N_KEY + N_SW;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [N-1:0]         raw;
    logic [N-1:0]         s1_q, s2_q;
    logic [N-1:0]         lvl_q, lvl_d;
    logic [N-1:0]         rise_q, rise_d;
    logic [N-1:0]         fall_q, fall_d;
    logic [N-1:0][CW-1:0] cnt_q, cnt_d;

    // keys are active-low on the board, so invert them before synchronising
    assign raw = {io.sw_raw, ~io.key_raw};

    always_comb begin
        lvl_d  = lvl_q;
        rise_d = '0;
        fall_d = '0;
        cnt_d  = '0;
        for (int i = 0; i < N; i++) begin
            if (s2_q[i] != lvl_q[i]) begin
                if (cnt_q[i] == LAST) begin
                    lvl_d[i]  = s2_q[i];
                    rise_d[i] = s2_q[i];
                    fall_d[i] = ~s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_q   <= '0;
            s2_q   <= '0;
            lvl_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            cnt_q  <= '0;
        end else begin
            s1_q   <= raw;
            s2_q   <= s1_q;
            lvl_q  <= lvl_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            cnt_q  <= cnt_d;
        end
    end

    assign io.key_level   = lvl_q[N_KEY-1:0];
    assign io.key_press   = rise_q[N_KEY-1:0];
    assign io.key_release = fall_q[N_KEY-1:0];
    assign io.sw_level    = lvl_q[N-1:N_KEY];
    assign io.sw_change   = rise_q[N-1:N_KEY] | fall_q[N-1:N_KEY];
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed plan plus random stimulus, scoreboarded against a sliding-window debounce model.
module tb_input_conditioner;
    localparam int NK = 4;
    localparam int NS = 18;
    localparam int N  = NK + NS;
    localparam int D  = 4;

    typedef struct packed {
        logic [NK-1:0] kl, kp, kr;
        logic [NS-1:0] sl, sc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    input_conditioner_if #(.N_KEY(NK), .N_SW(NS)) io ();

    input_conditioner #(.N_KEY(NK), .N_SW(NS), .DEBOUNCE_CYCLES(D)) dut (
        .clk  (clk),
        .reset(reset),
        .io   (io)
    );

    always #5 clk = ~clk;

    // Model: a channel accepts a new level once the last D synchronised samples all disagree with it.
    initial begin
        logic [N-1:0] s1m, s2m, lvl, rise, fall, raw_now;
        logic [N-1:0] zh[$];
        bit all_diff;
        s1m = '0; s2m = '0; lvl = '0; rise = '0; fall = '0;
        forever begin
            @(posedge clk);
            raw_now = {io.sw_raw, ~io.key_raw};
            rise = '0;
            fall = '0;
            if (!reset) begin
                s1m = '0; s2m = '0; lvl = '0;
                zh.delete();
            end else begin
                zh.push_back(s2m);
                if (zh.size() > D) void'(zh.pop_front());
                if (zh.size() == D) begin
                    for (int c = 0; c < N; c++) begin
                        all_diff = 1'b1;
                        for (int j = 0; j < D; j++) all_diff &= (zh[j][c] != lvl[c]);
                        if (all_diff) begin
                            lvl[c]  = ~lvl[c];
                            rise[c] = lvl[c];
                            fall[c] = ~lvl[c];
                        end
                    end
                end
                s2m = s1m;
                s1m = raw_now;
            end
            sb.push_back('{kl: lvl[NK-1:0], kp: rise[NK-1:0], kr: fall[NK-1:0],
                           sl: lvl[N-1:NK], sc: rise[N-1:NK] | fall[N-1:NK]});
        end
    end

    task automatic chk(input string nm, input logic [NS-1:0] got, input logic [NS-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("key_level",   NS'(io.key_level),   NS'(e.kl));
                chk("key_press",   NS'(io.key_press),   NS'(e.kp));
                chk("key_release", NS'(io.key_release), NS'(e.kr));
                chk("sw_level",    io.sw_level,         e.sl);
                chk("sw_change",   io.sw_change,        e.sc);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int rate;
        logic [N-1:0] flip;
        io.key_raw = 4'h0;
        io.sw_raw  = 18'h3FFFF;
        reset      = 1'b0;
        cyc(3);
        reset = 1'b1;
        cyc(10);
        io.key_raw = 4'hF;
        io.sw_raw  = '0;
        cyc(10);
        io.key_raw[0] = 1'b0;
        cyc(10);
        io.key_raw[0] = 1'b1;
        cyc(10);
        io.key_raw[1] = 1'b0;
        cyc(3);
        io.key_raw[1] = 1'b1;
        cyc(10);
        for (int i = 0; i < 4; i++) begin
            io.sw_raw[15] = i[0];
            cyc(1);
        end
        cyc(10);
        io.key_raw[2] = 1'b0;
        cyc(4);
        reset = 1'b0;
        cyc(2);
        reset = 1'b1;
        cyc(10);
        io.key_raw[2] = 1'b1;
        cyc(10);
        io.key_raw[3] = 1'b0;
        io.sw_raw[4:0] = 5'b10101;
        cyc(10);
        rate = 20;
        for (int t = 0; t < 1500; t++) begin
            if (t % 64 == 0) rate = ($urandom_range(1) == 0) ? 3 : 20;
            reset = ($urandom_range(199) != 0);
            for (int b = 0; b < N; b++) flip[b] = ($urandom_range(rate - 1) == 0);
            io.key_raw = io.key_raw ^ flip[NK-1:0];
            io.sw_raw  = io.sw_raw ^ flip[N-1:NK];
            cyc(1);
        end
        reset = 1'b1;
        cyc(12);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
